glip_channel_mux: RTL and testbench
===================================

# glip_channel_mux

Multiplexes `CHANNELS` independent logical streams onto the single GLIP FIFO stream, and demultiplexes the host stream back to those channels. Packets carry one header word followed by 1..`MAX_BURST` payload words. The block sits between the GLIP backend FIFO interface (TCP, USB or other) and the user logic. It lets several debug or data agents share one host link.

## Interface

Parameters:
- `WIDTH`, 16 — word width; ≥16.
- `CHANNELS`, 4 — number of logical channels; 1..256.
- `MAX_BURST`, 8 — maximum payload words per packet; 1..256.

Ports:
- `clk_logic`  in  1 — logic clock; all state is updated on its rising edge.
- `rst`  in  1 — reset; synchronous, active-high.
- `host_rx_data`  in  WIDTH — word from the host (backend → logic).
- `host_rx_valid`  in  1 — valid for `host_rx_data`.
- `host_rx_ready`  out  1 — the mux accepts the host word.
- `host_tx_data`  out  WIDTH — word to the host (logic → backend).
- `host_tx_valid`  out  1 — valid for `host_tx_data`.
- `host_tx_ready`  in  1 — the backend accepts the word.
- `ch_in_data`  out  WIDTH — payload to the channels; broadcast to all of them.
- `ch_in_valid`  out  CHANNELS — one-hot valid, one bit per channel.
- `ch_in_ready`  in  CHANNELS — per-channel ready.
- `ch_out_data`  in  CHANNELS*WIDTH — per-channel source data; channel c occupies bits [c*WIDTH +: WIDTH].
- `ch_out_valid`  in  CHANNELS — per-channel valid.
- `ch_out_ready`  out  CHANNELS — per-channel ready.
- `err_bad_channel`  out  1 — one-cycle pulse when a received header names a channel ≥ `CHANNELS`.

## Operation

Header format:
- Bits [7:0] hold length−1.
- Bits [15:8] hold the channel id.
- Bits [WIDTH-1:16] are 0 on TX and ignored on RX.

Handshake: a word transfers on a cycle where valid && ready.

TX FSM (channels → host):
- `TX_IDLE`: round-robin scan starting at `rr_ptr + 1` mod `CHANNELS`. The first channel with `ch_out_valid` set is latched as `tx_ch`; go to `TX_COLLECT`.
- `TX_COLLECT`: `ch_out_ready[tx_ch]` = 1; each transfer is written into the burst buffer and `cnt` increments.
  - Go to `TX_HDR` when `cnt` reaches `MAX_BURST`, or on the first cycle `ch_out_valid[tx_ch]` = 0 with `cnt` ≥ 1.
  - Once a channel is selected, it always contributes at least one word.
- `TX_HDR`: `host_tx_data` = {0, `tx_ch`, `cnt`−1}, `host_tx_valid` = 1. On transfer go to `TX_DRAIN`.
- `TX_DRAIN`: present buffer words in order. After the last word transfers, set `rr_ptr` = `tx_ch` and go to `TX_IDLE`.
- Every `ch_out_ready` bit is 0 in all states except `TX_COLLECT`.

RX FSM (host → channels):
- `RX_HDR`: `host_rx_ready` = 1. On header transfer, latch `rx_ch` and `rx_left` = length−1 (wrapping to 255 for length 256).
  - If `rx_ch` < `CHANNELS`, go to `RX_PAY`.
  - Otherwise pulse `err_bad_channel` and go to `RX_DROP`.
- `RX_PAY`:
  - `ch_in_valid` = `host_rx_valid` << `rx_ch`.
  - `ch_in_data` = `host_rx_data`.
  - `host_rx_ready` = `ch_in_ready[rx_ch]`.
  - Each transfer decrements `rx_left`. The transfer made with `rx_left` = 0 returns the FSM to `RX_HDR`.
- `RX_DROP`: `host_rx_ready` = 1. Consume length words, then return to `RX_HDR`.
- The RX and TX FSMs are fully independent; simultaneous activity on both is normal.

Reset values:
- Outputs: `host_tx_valid`=0, `host_rx_ready`=0, `ch_in_valid`=0, `ch_out_ready`=0, `err_bad_channel`=0, `host_tx_data`=0.
- State: `rr_ptr` = `CHANNELS`−1, so channel 0 wins first. FSMs in `TX_IDLE` and `RX_HDR`.
- Reset mid-packet discards buffered words and any partial RX packet. No header is emitted for that data.

## Timing

- `host_tx_valid`/`host_tx_data` are driven from registers only (state, `cnt`, buffer, read pointer). There is no combinational path from `host_tx_ready` to them.
- TX latency: first word collected at cycle N → header valid at N+2 at the earliest (end of collect detected at N+1).
- Back-to-back: `TX_DRAIN` → `TX_IDLE` → `TX_COLLECT`; one idle cycle between packets.
- `host_rx_ready` depends combinationally on `ch_in_ready` in `RX_PAY` only. In `RX_PAY`, `ch_in_valid` depends combinationally on `host_rx_valid`.
- The header word is never forwarded to a channel.

## Structure

- Package `glip_channel_mux_pkg` holds:
  - header field constants (`HDR_LEN_LSB`=0, `HDR_LEN_W`=8, `HDR_CH_LSB`=8, `HDR_CH_W`=8);
  - enums `tx_state_t` and `rx_state_t`.
- Sub-module `glip_burst_buffer`, parameters `WIDTH`, `DEPTH`:
  - register array with write count and read pointer;
  - clear input;
  - outputs count, read data, and last.

## Test plan

- Reset, then ch1 sends 3 words 0xA1,0xA2,0xA3 → host receives 0x0102,0xA1,0xA2,0xA3.
- ch0 holds valid for 10 words with `MAX_BURST`=8 → header 0x0007 plus 8 words, then header 0x0001 plus 2 words.
- ch0 and ch2 both valid continuously → packets alternate ch0, ch2, ch0; no starvation.
- Host sends 0x0302,0x11,0x22,0x33 while ch3 ready toggles every cycle → ch3 receives 0x11,0x22,0x33 in order, and no other `ch_in_valid` bit ever asserts.
- Host sends 0x0901,0xDE,0xAD with `CHANNELS`=4 → one `err_bad_channel` pulse, no `ch_in_valid`, and the next header is parsed correctly.
- `rst` asserted during `TX_DRAIN` with the backend stalled → `host_tx_valid`=0 the next cycle, and the remaining words are never sent.

Source files
------------

// File: rtl/glip_channel_mux_pkg.sv
// Shared header layout and FSM state types
// for the GLIP channel multiplexer.
package glip_channel_mux_pkg;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 8;
  localparam int HDR_CH_LSB  = 8;
  localparam int HDR_CH_W    = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_COLLECT,
    TX_HDR,
    TX_DRAIN
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_PAY,
    RX_DROP
  } rx_state_t;

  function automatic logic [15:0] hdr_pack(
    input logic [HDR_CH_W-1:0]  ch,
    input logic [HDR_LEN_W-1:0] len_m1
  );
    logic [15:0] h;
    h = '0;
    h[HDR_CH_LSB +: HDR_CH_W]   = ch;
    h[HDR_LEN_LSB +: HDR_LEN_W] = len_m1;
    return h;
  endfunction

endpackage

// File: rtl/glip_channel_mux_if.sv
// Host FIFO stream and per-channel streams
// of the GLIP channel multiplexer.
interface glip_channel_mux_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic [WIDTH-1:0]          host_rx_data;
  logic                      host_rx_valid;
  logic                      host_rx_ready;
  logic [WIDTH-1:0]          host_tx_data;
  logic                      host_tx_valid;
  logic                      host_tx_ready;
  logic [WIDTH-1:0]          ch_in_data;
  logic [CHANNELS-1:0]       ch_in_valid;
  logic [CHANNELS-1:0]       ch_in_ready;
  logic [CHANNELS*WIDTH-1:0] ch_out_data;
  logic [CHANNELS-1:0]       ch_out_valid;
  logic [CHANNELS-1:0]       ch_out_ready;
  logic                      err_bad_channel;

  modport master (
    input  host_rx_data,
    input  host_rx_valid,
    output host_rx_ready,
    output host_tx_data,
    output host_tx_valid,
    input  host_tx_ready,
    output ch_in_data,
    output ch_in_valid,
    input  ch_in_ready,
    input  ch_out_data,
    input  ch_out_valid,
    output ch_out_ready,
    output err_bad_channel
  );

  modport slave (
    output host_rx_data,
    output host_rx_valid,
    input  host_rx_ready,
    input  host_tx_data,
    input  host_tx_valid,
    output host_tx_ready,
    input  ch_in_data,
    input  ch_in_valid,
    output ch_in_ready,
    output ch_out_data,
    output ch_out_valid,
    input  ch_out_ready,
    input  err_bad_channel
  );
endinterface

// File: rtl/glip_burst_buffer.sv
// Register-array burst buffer: fill once,
// then read back in order, then clear.
module glip_burst_buffer #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 8,
  localparam int CNTW  = $clog2(DEPTH + 1),
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_logic,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [CNTW-1:0]  o_count,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_last
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNTW-1:0]  r_cnt;
  logic [PTRW-1:0]  r_rptr;
  logic [PTRW-1:0]  w_wptr;

  assign w_wptr = PTRW'(r_cnt);

  always_ff @(posedge clk_logic) begin
    if (i_wr) r_mem[w_wptr] <= i_wdata;
  end

  always_ff @(posedge clk_logic) begin
    if (rst || i_clr) begin
      r_cnt  <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr) r_cnt  <= r_cnt + CNTW'(1);
      if (i_rd) r_rptr <= r_rptr + PTRW'(1);
    end
  end

  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rptr];
  assign o_last  = (CNTW'(r_rptr) + CNTW'(1)) == r_cnt;

endmodule

// File: rtl/glip_channel_mux.sv
// Muxes CHANNELS streams onto one GLIP FIFO
// stream as header+payload packets, and back.
module glip_channel_mux
  import glip_channel_mux_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk_logic,
  input logic rst,
  glip_channel_mux_if.master bus
);

  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(MAX_BURST + 1);

  tx_state_t        r_tx_st, w_tx_nx;
  logic [CW-1:0]    r_tx_ch, r_rr;
  logic [CW-1:0]    w_pick, w_idx;
  logic             w_found, w_tx_go;
  logic             w_src_valid;
  logic [WIDTH-1:0] w_src_data;
  logic [CNTW-1:0]  w_cnt;
  logic [WIDTH-1:0] w_buf_rdata;
  logic             w_buf_last;
  logic             w_buf_wr, w_buf_rd, w_buf_clr;

  // Round-robin scan starting one past the last winner
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      w_idx = CW'((int'(r_rr) + i) % CHANNELS);
      if (!w_found && bus.ch_out_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_src_valid = bus.ch_out_valid[r_tx_ch];
  assign w_src_data  =
    bus.ch_out_data[r_tx_ch*WIDTH +: WIDTH];

  glip_burst_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_BURST)
  ) u_buf (
    .clk_logic (clk_logic),
    .rst       (rst),
    .i_clr     (w_buf_clr),
    .i_wr      (w_buf_wr),
    .i_wdata   (w_src_data),
    .i_rd      (w_buf_rd),
    .o_count   (w_cnt),
    .o_rdata   (w_buf_rdata),
    .o_last    (w_buf_last)
  );

  always_comb begin
    w_tx_nx           = r_tx_st;
    w_tx_go           = 1'b0;
    w_buf_wr          = 1'b0;
    w_buf_rd          = 1'b0;
    w_buf_clr         = 1'b0;
    bus.ch_out_ready  = '0;
    bus.host_tx_valid = 1'b0;
    bus.host_tx_data  = '0;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (w_found) begin
          w_tx_go = 1'b1;
          w_tx_nx = TX_COLLECT;
        end
      end
      TX_COLLECT: begin
        bus.ch_out_ready[r_tx_ch] = 1'b1;
        w_buf_wr = w_src_valid;
        if (w_src_valid &&
            w_cnt == CNTW'(MAX_BURST - 1))
          w_tx_nx = TX_HDR;
        else if (!w_src_valid && w_cnt != '0)
          w_tx_nx = TX_HDR;
      end
      TX_HDR: begin
        bus.host_tx_valid = 1'b1;
        bus.host_tx_data  = WIDTH'(hdr_pack(
          8'(r_tx_ch), 8'(w_cnt - CNTW'(1))));
        if (bus.host_tx_ready) w_tx_nx = TX_DRAIN;
      end
      TX_DRAIN: begin
        bus.host_tx_valid = 1'b1;
        bus.host_tx_data  = w_buf_rdata;
        if (bus.host_tx_ready) begin
          w_buf_rd = 1'b1;
          if (w_buf_last) begin
            w_buf_clr = 1'b1;
            w_tx_nx   = TX_IDLE;
          end
        end
      end
      default: w_tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (rst) begin
      r_tx_st <= TX_IDLE;
      r_tx_ch <= '0;
      r_rr    <= CW'(CHANNELS - 1);
    end else begin
      r_tx_st <= w_tx_nx;
      if (w_tx_go)   r_tx_ch <= w_pick;
      if (w_buf_clr) r_rr    <= r_tx_ch;
    end
  end

  rx_state_t     r_rx_st, w_rx_nx;
  logic [7:0]    r_rx_ch, r_rx_left;
  logic          r_err;
  logic [7:0]    w_hdr_ch, w_hdr_len;
  logic          w_ch_ok, w_rx_fire;
  logic [CW-1:0] w_rx_sel;

  assign w_hdr_ch  =
    bus.host_rx_data[HDR_CH_LSB +: HDR_CH_W];
  assign w_hdr_len =
    bus.host_rx_data[HDR_LEN_LSB +: HDR_LEN_W];
  assign w_ch_ok   = int'(w_hdr_ch) < CHANNELS;
  assign w_rx_sel  = r_rx_ch[CW-1:0];
  assign w_rx_fire =
    bus.host_rx_valid && bus.host_rx_ready;

  always_comb begin
    w_rx_nx           = r_rx_st;
    bus.host_rx_ready = 1'b0;
    bus.ch_in_valid   = '0;
    bus.ch_in_data    = '0;
    unique case (r_rx_st)
      RX_HDR: begin
        bus.host_rx_ready = 1'b1;
        if (bus.host_rx_valid)
          w_rx_nx = w_ch_ok ? RX_PAY : RX_DROP;
      end
      RX_PAY: begin
        bus.ch_in_valid[w_rx_sel] = bus.host_rx_valid;
        bus.ch_in_data    = bus.host_rx_data;
        bus.host_rx_ready = bus.ch_in_ready[w_rx_sel];
        if (bus.host_rx_valid &&
            bus.ch_in_ready[w_rx_sel] &&
            r_rx_left == '0)
          w_rx_nx = RX_HDR;
      end
      RX_DROP: begin
        bus.host_rx_ready = 1'b1;
        if (bus.host_rx_valid && r_rx_left == '0)
          w_rx_nx = RX_HDR;
      end
      default: w_rx_nx = RX_HDR;
    endcase
    // Nothing is accepted or offered while held in reset
    if (rst) begin
      bus.host_rx_ready = 1'b0;
      bus.ch_in_valid   = '0;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (rst) begin
      r_rx_st   <= RX_HDR;
      r_rx_ch   <= '0;
      r_rx_left <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rx_st <= w_rx_nx;
      r_err   <= 1'b0;
      if (w_rx_fire) begin
        if (r_rx_st == RX_HDR) begin
          r_rx_ch   <= w_hdr_ch;
          r_rx_left <= w_hdr_len;
          r_err     <= !w_ch_ok;
        end else begin
          r_rx_left <= r_rx_left - 8'd1;
        end
      end
    end
  end

  assign bus.err_bad_channel = r_err;

endmodule

// File: tb/tb_glip_channel_mux.sv
// Randomized bench for glip_channel_mux with
// a packet-level reference model.
module tb_glip_channel_mux;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int MB = 8;

  logic clk_logic = 1'b0;
  logic rst = 1'b1;

  always #5 clk_logic = ~clk_logic;

  glip_channel_mux_if #(
    .WIDTH    (W),
    .CHANNELS (CH)
  ) bus ();

  glip_channel_mux #(
    .WIDTH     (W),
    .CHANNELS  (CH),
    .MAX_BURST (MB)
  ) dut (
    .clk_logic (clk_logic),
    .rst       (rst),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  logic [W-1:0] src [CH][$];
  logic [W-1:0] exp_in [CH][$];
  logic [W-1:0] exp_tx [$];
  logic [W-1:0] host_q [$];
  int txr_mode, rxr_mode;
  int exp_err, n_err, n_txw, n_extra, n_spur, cyc;

  task automatic drive();
    case (txr_mode)
      0:       bus.host_tx_ready = 1'b0;
      1:       bus.host_tx_ready = 1'b1;
      default: bus.host_tx_ready =
                 ($urandom_range(0, 9) < 7);
    endcase
    bus.host_rx_valid = (host_q.size() != 0) &&
                        ($urandom_range(0, 9) < 8);
    bus.host_rx_data  =
      (host_q.size() != 0) ? host_q[0] : '0;
    for (int c = 0; c < CH; c++) begin
      bus.ch_out_valid[c] = (src[c].size() != 0);
      bus.ch_out_data[c*W +: W] =
        (src[c].size() != 0) ? src[c][0] : '0;
      if (rxr_mode == 0)
        bus.ch_in_ready[c] = cyc[0];
      else
        bus.ch_in_ready[c] = $urandom_range(0, 1) != 0;
    end
  endtask

  task automatic step();
    logic [CH-1:0] in_v;
    @(negedge clk_logic);
    if (bus.host_tx_valid && bus.host_tx_ready) begin
      n_txw++;
      if (exp_tx.size() != 0)
        chk("tx_word", bus.host_tx_data,
            exp_tx.pop_front());
      else
        n_extra++;
    end
    if (bus.host_rx_valid && bus.host_rx_ready)
      void'(host_q.pop_front());
    in_v = bus.ch_in_valid;
    if (in_v != '0)
      chk("chin_onehot", $countones(in_v), 1);
    for (int c = 0; c < CH; c++) begin
      if (in_v[c]) begin
        if (exp_in[c].size() == 0)
          n_spur++;
        else if (bus.ch_in_ready[c])
          chk("chin_data", bus.ch_in_data,
              exp_in[c].pop_front());
      end
      if (bus.ch_out_valid[c] && bus.ch_out_ready[c])
        void'(src[c].pop_front());
    end
    if (bus.err_bad_channel) n_err++;
    @(posedge clk_logic);
    #1;
    cyc++;
    drive();
  endtask

  // Expected host stream: round-robin over non-empty
  // sources, each grant taking up to MB words
  task automatic model_tx();
    int rr, pick, n;
    int pos [CH];
    rr = CH - 1;
    for (int c = 0; c < CH; c++) pos[c] = 0;
    while (1) begin
      pick = -1;
      for (int i = 1; i <= CH; i++)
        if (pick < 0 &&
            pos[(rr + i) % CH] < src[(rr + i) % CH].size())
          pick = (rr + i) % CH;
      if (pick < 0) break;
      n = src[pick].size() - pos[pick];
      if (n > MB) n = MB;
      exp_tx.push_back(W'(pick * 256 + n - 1));
      for (int k = 0; k < n; k++)
        exp_tx.push_back(src[pick][pos[pick] + k]);
      pos[pick] += n;
      rr = pick;
    end
  endtask

  task automatic add_rx(input int ch, input int len,
                        input logic [W-1:0] first,
                        input logic [W-1:0] stp);
    logic [W-1:0] w;
    host_q.push_back(W'(ch * 256 + len - 1));
    w = first;
    for (int k = 0; k < len; k++) begin
      host_q.push_back(w);
      if (ch < CH) exp_in[ch].push_back(w);
      w = w + stp;
    end
    if (ch >= CH) exp_err++;
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_tx.size() == 0) && (host_q.size() == 0);
    for (int c = 0; c < CH; c++)
      if (exp_in[c].size() != 0 || src[c].size() != 0)
        d = 1'b0;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive();
    step();
    step();
    chk("rst_tx_valid", bus.host_tx_valid, 0);
    chk("rst_tx_data", bus.host_tx_data, 0);
    chk("rst_rx_ready", bus.host_rx_ready, 0);
    chk("rst_in_valid", bus.ch_in_valid, 0);
    chk("rst_out_ready", bus.ch_out_ready, 0);
    chk("rst_err", bus.err_bad_channel, 0);
    rst = 1'b0;
    exp_err = 0;
    n_err   = 0;
    n_extra = 0;
    n_spur  = 0;
    drive();
  endtask

  task automatic run_phase(input string tag,
                           input int budget);
    int i;
    i = 0;
    while (!all_done() && i < budget) begin
      step();
      i++;
    end
    repeat (20) step();
    chk({tag, "_tx_left"}, exp_tx.size(), 0);
    chk({tag, "_rx_left"}, host_q.size(), 0);
    for (int c = 0; c < CH; c++)
      chk({tag, "_chin_left"}, exp_in[c].size(), 0);
    chk({tag, "_tx_extra"}, n_extra, 0);
    chk({tag, "_chin_spur"}, n_spur, 0);
    chk({tag, "_err_cnt"}, n_err, exp_err);
  endtask

  initial begin
    int i;
    txr_mode = 1;
    rxr_mode = 1;
    cyc = 0;
    exp_err = 0;
    n_err = 0;
    n_txw = 0;
    n_extra = 0;
    n_spur = 0;
    drive();

    do_reset();
    src[1] = '{16'h00A1, 16'h00A2, 16'h00A3};
    model_tx();
    run_phase("ch1_three", 200);

    do_reset();
    for (int k = 0; k < 10; k++)
      src[0].push_back(W'(16'h0100 + k));
    model_tx();
    run_phase("ch0_ten", 300);

    do_reset();
    for (int k = 0; k < 16; k++) begin
      src[0].push_back(W'(16'h0200 + k));
      src[2].push_back(W'(16'h2200 + k));
    end
    model_tx();
    run_phase("rr_02", 400);

    do_reset();
    rxr_mode = 0;
    add_rx(3, 3, 16'h0011, 16'h0011);
    add_rx(9, 2, 16'h00DE, 16'hFFCF);
    add_rx(1, 1, 16'h0055, 16'h0000);
    drive();
    run_phase("rx_dir", 300);

    rxr_mode = 1;
    txr_mode = 2;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < CH; c++) begin
        int n;
        n = $urandom_range(0, 20);
        for (int k = 0; k < n; k++)
          src[c].push_back(W'($urandom));
      end
      model_tx();
      for (int p = 0; p < 10; p++)
        add_rx($urandom_range(0, 5),
               $urandom_range(1, 12),
               W'($urandom), W'($urandom));
      drive();
      run_phase("rand", 3000);
    end

    txr_mode = 1;
    do_reset();
    for (int k = 0; k < 5; k++)
      src[1].push_back(W'(16'h0300 + k));
    exp_tx.push_back(16'h0104);
    drive();
    i = 0;
    while (exp_tx.size() != 0 && i < 100) begin
      step();
      i++;
    end
    chk("drain_hdr_seen", exp_tx.size(), 0);
    txr_mode = 0;
    drive();
    repeat (3) step();
    rst = 1'b1;
    drive();
    step();
    chk("rst_drain_valid", bus.host_tx_valid, 0);
    rst = 1'b0;
    n_txw = 0;
    txr_mode = 1;
    drive();
    repeat (30) step();
    chk("rst_drain_words", n_txw, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
